// File: rtl/pkt_out_sched_pkg.sv
// ---------------------------------------------------------------------------
// pkt_out_sched_pkg
// Shared definitions for the per-output packet scheduler:
//   - scheduler FSM state encoding (IDLE / HDR / BODY)
//   - position and default width of the payload-length field in the header
// No ports (package).
// ---------------------------------------------------------------------------
package pkt_out_sched_pkg;

    // Scheduler FSM: IDLE arbitrates, HDR sends the header, BODY sends payload+CRC.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } sched_state_e;

    // The payload byte count sits in the low bits of the header byte.
    localparam int HDR_LEN_LSB   = 0;
    localparam int DEF_LEN_WIDTH = 6;

endpackage

// File: rtl/pkt_out_sched_if.sv
// ---------------------------------------------------------------------------
// pkt_out_sched_if
// Bundles the FIFO-side and output-stream-side signals of pkt_out_sched.
//   pkt_commit [NUM_PORTS]            : one complete good packet landed in FIFO i
//   fifo_empty [NUM_PORTS]            : FIFO i empty
//   fifo_data  [NUM_PORTS*DATA_WIDTH] : FWFT head byte of FIFO i (slice i)
//   fifo_pop   [NUM_PORTS]            : pop strobe, at most one bit high
//   out_data/out_valid/out_ready      : byte stream to the output port
//   out_sop/out_eop                   : header byte / CRC (last) byte markers
//   out_src    [PORT_WIDTH]           : index of the granted FIFO
// Modports: master = scheduler view, slave = FIFOs + downstream view.
// ---------------------------------------------------------------------------
interface pkt_out_sched_if
    import pkt_out_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);

    logic [NUM_PORTS-1:0]            pkt_commit;
    logic [NUM_PORTS-1:0]            fifo_empty;
    logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data;
    logic [NUM_PORTS-1:0]            fifo_pop;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_sop;
    logic                            out_eop;
    logic [PORT_WIDTH-1:0]           out_src;

    modport master (
        input  pkt_commit, fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_data, out_valid, out_sop, out_eop, out_src
    );

    modport slave (
        output pkt_commit, fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_data, out_valid, out_sop, out_eop, out_src
    );

endinterface

// File: rtl/pkt_out_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pkt_out_sched_rr_arbiter
// Round-robin pick among requesting ports. The search starts one above the
// last granted port and wraps, so the most recently served port has lowest
// priority. The pointer advances only when a grant is accepted (en && found).
//   clk, rst    : clock, asynchronous active-high reset
//   req         : per-port request (port has a committed packet pending)
//   en          : arbitration enabled this cycle (scheduler idle)
//   grant_idx   : chosen port index (valid when grant_found)
//   grant_found : at least one port is requesting
// ---------------------------------------------------------------------------
module pkt_out_sched_rr_arbiter
    import pkt_out_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PORTS-1:0]  req,
    input  logic                  en,
    output logic [PORT_WIDTH-1:0] grant_idx,
    output logic                  grant_found
);

    // Reset pointer to the top port so port 0 is searched first.
    localparam logic [PORT_WIDTH-1:0] RR_RESET = PORT_WIDTH'(NUM_PORTS - 1);

    logic [PORT_WIDTH-1:0] rr_ptr;

    // Search rr_ptr+1 .. rr_ptr+NUM_PORTS (mod NUM_PORTS) for the first request
    always_comb begin
        int                    cand;
        logic [PORT_WIDTH-1:0] cand_idx;
        logic                  hit;
        grant_found = 1'b0;
        grant_idx   = {PORT_WIDTH{1'b0}};
        cand        = 0;
        cand_idx    = {PORT_WIDTH{1'b0}};
        hit         = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand        = (int'(rr_ptr) + k) % NUM_PORTS;
            cand_idx    = PORT_WIDTH'(cand);
            hit         = !grant_found && req[cand_idx];
            grant_idx   = hit ? cand_idx : grant_idx;
            grant_found = grant_found | req[cand_idx];
        end
    end

    // Pointer register: remembers the last accepted grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= RR_RESET;
        end else if (en && grant_found) begin
            rr_ptr <= grant_idx;
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

endmodule

// File: rtl/pkt_out_sched.sv
// ---------------------------------------------------------------------------
// pkt_out_sched
// Per-output packet scheduler. Counts committed packets per input FIFO,
// round-robins among FIFOs with at least one committed packet, then streams
// that whole packet (header + LEN payload + CRC) onto the output. Only
// committed packets are ever read, so a packet still being written (and
// possibly flushed) is never touched, and packets never interleave.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pkt_out_sched_if.master (FIFO side + output stream)
//   busy     : a packet is in progress (state != IDLE)
//   cnt_ovf  : sticky, a commit arrived while its counter was saturated
// ---------------------------------------------------------------------------
module pkt_out_sched
    import pkt_out_sched_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    pkt_out_sched_if.master bus,
    output logic            busy,
    output logic            cnt_ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    // rem is one bit wider than LEN so that LEN+1 never wraps.
    localparam logic [LEN_WIDTH:0]   REM_ONE  = {{LEN_WIDTH{1'b0}}, 1'b1};

    sched_state_e          state, state_next;
    logic [PORT_WIDTH-1:0] grant, grant_next;
    logic [LEN_WIDTH:0]    rem, rem_next;

    logic [CNT_WIDTH-1:0]  pend      [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  pend_next [NUM_PORTS];
    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  dec_vec;
    logic                  ovf_hit;

    logic                  arb_en;
    logic                  arb_found;
    logic [PORT_WIDTH-1:0] arb_idx;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_empty;
    logic                  xfer;
    logic                  hdr_xfer;

    pkt_out_sched_rr_arbiter #(
        .NUM_PORTS  (NUM_PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .en          (arb_en),
        .grant_idx   (arb_idx),
        .grant_found (arb_found)
    );

    // Select the granted FIFO's head byte and empty flag
    always_comb begin
        sel_data  = {DATA_WIDTH{1'b0}};
        sel_empty = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_data  = (grant == PORT_WIDTH'(i)) ? bus.fifo_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data;
            sel_empty = (grant == PORT_WIDTH'(i)) ? bus.fifo_empty[i] : sel_empty;
        end
    end

    // The output stream is a direct view of the granted FIFO; a FIFO that runs
    // dry mid-packet just drops out_valid until more bytes arrive.
    assign bus.out_data  = sel_data;
    assign bus.out_valid = (state != ST_IDLE) && !sel_empty;
    assign bus.out_sop   = (state == ST_HDR);
    assign bus.out_eop   = (state == ST_BODY) && (rem == REM_ONE);
    assign bus.out_src   = grant;
    assign busy          = (state != ST_IDLE);
    assign xfer          = bus.out_valid && bus.out_ready;
    assign hdr_xfer      = xfer && (state == ST_HDR);

    // Pop strobe to the granted FIFO on every accepted byte
    always_comb begin
        bus.fifo_pop = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.fifo_pop[i] = xfer && (grant == PORT_WIDTH'(i));
        end
    end

    // A header transfer consumes one committed packet of the granted port
    assign dec_vec = bus.fifo_pop & {NUM_PORTS{hdr_xfer}};

    // Request vector for the arbiter: ports with a committed packet waiting
    always_comb begin
        req = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = (pend[i] != CNT_ZERO);
        end
    end

    // Pending-packet counter next values; saturate and flag on overflow
    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pend_next[i] = pend[i];
            case ({bus.pkt_commit[i], dec_vec[i]})
                2'b10: begin
                    if (pend[i] == CNT_MAX) begin
                        pend_next[i] = pend[i];
                        ovf_hit      = 1'b1;
                    end else begin
                        pend_next[i] = pend[i] + CNT_ONE;
                    end
                end
                2'b01:   pend_next[i] = pend[i] - CNT_ONE;
                default: pend_next[i] = pend[i];
            endcase
        end
    end

    // Counter and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend[i] <= CNT_ZERO;
            end
            cnt_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend[i] <= pend_next[i];
            end
            cnt_ovf <= cnt_ovf | ovf_hit;
        end
    end

    // FSM next state, grant capture and remaining-byte counter
    always_comb begin
        state_next = state;
        grant_next = grant;
        rem_next   = rem;
        arb_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (arb_found) begin
                    grant_next = arb_idx;
                    state_next = ST_HDR;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    // payload bytes plus the trailing CRC byte
                    rem_next   = {1'b0, bus.out_data[HDR_LEN_LSB +: LEN_WIDTH]} + REM_ONE;
                    state_next = ST_BODY;
                end else begin
                    state_next = ST_HDR;
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    rem_next = rem - REM_ONE;
                    if (rem == REM_ONE) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_BODY;
                    end
                end else begin
                    state_next = ST_BODY;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and rem registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= {PORT_WIDTH{1'b0}};
            rem   <= {(LEN_WIDTH+1){1'b0}};
        end else begin
            state <= state_next;
            grant <= grant_next;
            rem   <= rem_next;
        end
    end

endmodule

// File: tb/tb_pkt_out_sched.sv
// ---------------------------------------------------------------------------
// tb_pkt_out_sched
// Self-checking bench for pkt_out_sched. Models the input FIFOs as queues,
// pushes every expected output byte to a scoreboard when a packet is loaded,
// and compares each accepted output byte against the scoreboard head.
// ---------------------------------------------------------------------------
module tb_pkt_out_sched;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int DW = 8;

    typedef struct packed {
        logic [PW-1:0] src;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
    logic cnt_ovf;

    pkt_out_sched_if #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    pkt_out_sched #(
        .NUM_PORTS  (NP),
        .PORT_WIDTH (PW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (6),
        .CNT_WIDTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .cnt_ovf (cnt_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] fq [NP][$];
    exp_t          sb [$];
    int            pop_cnt [NP];
    logic [NP-1:0] pop_s = '0;
    logic          after_eop = 1'b0;
    logic          stalled = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input int port, input logic [DW-1:0] b, input logic sop, input logic eop);
        exp_t e;
        fq[port].push_back(b);
        e.src  = PW'(port);
        e.data = b;
        e.sop  = sop;
        e.eop  = eop;
        sb.push_back(e);
    endtask

    // Loads one packet into FIFO 'port' and its expected bytes into the scoreboard
    task automatic send_pkt(input int port, input int len, input logic [DW-1:0] hdr_hi, input logic [DW-1:0] seed);
        logic [DW-1:0] b;
        logic [DW-1:0] crc;
        b   = hdr_hi | DW'(len);
        crc = b;
        push_byte(port, b, 1'b1, 1'b0);
        for (int k = 0; k < len; k++) begin
            b   = seed + DW'(k);
            crc = crc ^ b;
            push_byte(port, b, 1'b0, 1'b0);
        end
        push_byte(port, crc ^ 8'hA5, 1'b0, 1'b1);
    endtask

    task automatic commit(input logic [NP-1:0] mask);
        bus.pkt_commit = mask;
        step();
        bus.pkt_commit = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'((sb.size() == 0) && !busy), 32'd1);
    endtask

    // FIFO model: apply the pop seen last cycle, then present the new head
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (pop_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            bus.fifo_empty[i] <= (fq[i].size() == 0);
            bus.fifo_data[i*DW +: DW] <= (fq[i].size() > 0) ? fq[i][0] : 8'h00;
        end
    end

    // Output monitor: scoreboard compare, stall behaviour, post-EOP bubble
    always @(negedge clk) begin
        exp_t e;
        pop_s = bus.fifo_pop;
        if (rst) begin
            after_eop = 1'b0;
            stalled   = 1'b0;
        end else begin
            if (after_eop) chk("eop_bubble", {bus.out_valid, busy}, 2'b00);
            after_eop = 1'b0;
            if (!bus.out_ready) chk("no_pop_while_not_ready", bus.fifo_pop, 4'b0000);
            if (stalled) chk("data_hold_while_stalled", bus.out_data, stall_data);
            if (bus.out_valid && bus.out_ready) begin
                chk("byte_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_byte{src,data,sop,eop}",
                        {bus.out_src, bus.out_data, bus.out_sop, bus.out_eop}, e);
                    chk("pop_onehot", bus.fifo_pop, 4'b0001 << e.src);
                end
                pop_cnt[bus.out_src]++;
                after_eop = bus.out_eop;
            end
            stalled    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base0, base1, base2, base3;
        logic [3:0] rdy_pat;
        rdy_pat = 4'b1001;
        for (int i = 0; i < NP; i++) pop_cnt[i] = 0;
        rst = 1'b1;
        bus.pkt_commit = '0;
        bus.out_ready  = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_outputs{valid,pop,sop,eop,busy,ovf,src}",
            {bus.out_valid, bus.fifo_pop, bus.out_sop, bus.out_eop, busy, cnt_ovf, bus.out_src},
            {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        step();
        rst = 1'b0;
        step();

        // Round-robin from reset: ports 0, 1, 3 committed together -> order 0, 1, 3
        bus.out_ready = 1'b1;
        base0 = pop_cnt[0]; base1 = pop_cnt[1]; base3 = pop_cnt[3];
        send_pkt(0, 1, 8'h00, 8'h10);
        send_pkt(1, 2, 8'h00, 8'h20);
        send_pkt(3, 0, 8'h00, 8'h30);
        step();
        commit(4'b1011);
        wait_drain("rr_drain", 60);
        chk("rr_pops_p0", pop_cnt[0] - base0, 3);
        chk("rr_pops_p1", pop_cnt[1] - base1, 4);
        chk("rr_pops_p3", pop_cnt[3] - base3, 2);

        // Single packet on port 2: out_valid rises two cycles after the commit
        base2 = pop_cnt[2];
        send_pkt(2, 3, 8'h00, 8'hA1);
        step();
        bus.pkt_commit = 4'b0100;
        @(negedge clk);
        chk("lat_commit_cycle_valid", bus.out_valid, 1'b0);
        step();
        bus.pkt_commit = 4'b0000;
        @(negedge clk);
        chk("lat_t1_valid_busy", {bus.out_valid, busy}, 2'b00);
        step();
        @(negedge clk);
        chk("lat_t2_valid_sop_src", {bus.out_valid, bus.out_sop, bus.out_src}, {1'b1, 1'b1, 2'd2});
        wait_drain("single_drain", 30);
        chk("single_pops_p2", pop_cnt[2] - base2, 5);
        chk("single_busy_after", busy, 1'b0);

        // Backpressure: out_ready pattern 1,0,0,1 during a LEN=5 packet
        base0 = pop_cnt[0];
        send_pkt(0, 5, 8'h00, 8'h50);
        step();
        bus.pkt_commit = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            bus.out_ready = rdy_pat[k % 4];
            step();
            bus.pkt_commit = 4'b0000;
            if (k > 2 && sb.size() == 0 && !busy) break;
        end
        bus.out_ready = 1'b1;
        wait_drain("bp_drain", 20);
        chk("bp_pops_p0", pop_cnt[0] - base0, 7);

        // Commit on port 1 in the same cycle as its header transfer
        send_pkt(1, 2, 8'h00, 8'h60);
        send_pkt(1, 1, 8'h00, 8'h70);
        step();
        bus.pkt_commit = 4'b0010;
        step();
        bus.pkt_commit = 4'b0000;
        step();
        bus.pkt_commit = 4'b0010;
        @(negedge clk);
        chk("sim_hdr_xfer{valid,sop,src}", {bus.out_valid, bus.out_sop, bus.out_src}, {1'b1, 1'b1, 2'd1});
        step();
        bus.pkt_commit = 4'b0000;
        wait_drain("sim_drain", 40);
        repeat (4) step();
        chk("sim_no_extra_packet", busy, 1'b0);

        // LEN=0 packet with upper header bits set: 2 bytes, EOP on byte 1
        send_pkt(3, 0, 8'hC0, 8'h00);
        step();
        commit(4'b1000);
        wait_drain("len0_drain", 20);

        // Counter saturation: 15 commits fit, the 16th sets cnt_ovf
        bus.out_ready = 1'b0;
        bus.pkt_commit = 4'b0001;
        repeat (15) step();
        bus.pkt_commit = 4'b0000;
        @(negedge clk);
        chk("ovf_after_15", cnt_ovf, 1'b0);
        step();
        commit(4'b0001);
        @(negedge clk);
        chk("ovf_after_16", cnt_ovf, 1'b1);
        repeat (3) step();
        chk("ovf_sticky", cnt_ovf, 1'b1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("ovf_cleared_by_rst", {cnt_ovf, busy}, 2'b00);
        step();
        rst = 1'b0;
        step();

        // Reset asserted mid-packet aborts at once; then normal service resumes
        bus.out_ready = 1'b1;
        send_pkt(2, 4, 8'h00, 8'h80);
        step();
        commit(4'b0100);
        repeat (3) step();
        @(negedge clk);
        chk("mid_in_body{busy,sop,eop}", {busy, bus.out_sop, bus.out_eop}, 3'b100);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs{valid,pop,sop,eop,busy,src}",
            {bus.out_valid, bus.fifo_pop, bus.out_sop, bus.out_eop, busy, bus.out_src},
            {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0});
        sb.delete();
        fq[2].delete();
        step();
        step();
        rst = 1'b0;
        step();
        base1 = pop_cnt[1];
        send_pkt(1, 2, 8'h00, 8'h90);
        step();
        commit(4'b0010);
        wait_drain("post_rst_drain", 30);
        chk("post_rst_pops_p1", pop_cnt[1] - base1, 4);
        chk("scoreboard_left", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
